// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
//
// Purpose:
//   N-channel leaky integrate-and-fire neuron array. A window starts with a
//   start pulse, which captures the firing threshold and the post-spike reset
//   mode. T input beats follow, each carrying one Q-bit value per channel.
//   Each beat updates every channel's saturating P-bit membrane potential and
//   records one spike bit. After the T-th beat the N x T spike map is offered
//   on a valid/ready output. It stays stable until it is accepted.
//
// Configuration:
//   LIF_LEAK_EN  when defined, each potential leaks by V >> LEAK_SHIFT (floor)
//                before the input is added. When undefined, the array is a pure
//                integrate-and-fire array and LEAK_SHIFT has no effect.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous, active-low reset
//   start        begin a window (sampled only while idle)
//   threshold    firing threshold, captured with start
//   reset_mode   0 = reset-to-zero, 1 = reset-by-subtraction, captured with start
//   in_valid     input beat valid
//   in_ready     array accepts a beat (high only while accumulating)
//   in_data      channel n input in bits [n*Q +: Q]
//   out_valid    spike map valid (high only while presenting output)
//   out_ready    downstream accepts the spike map
//   spike_out    channel n spike at timestep t in bit [n*T + t]
//   busy         a window is in progress
// -----------------------------------------------------------------------------
module lif_neuron_array #(
   parameter int N          = 4,
   parameter int T          = 8,
   parameter int Q          = 8,
   parameter int P          = 10,
   parameter int LEAK_SHIFT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [P-1:0]   threshold,
   input  logic           reset_mode,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*Q-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*T-1:0] spike_out,
   output logic           busy
);

   localparam int CW = (T > 1) ? $clog2(T) : 1;
   localparam logic [CW-1:0] LAST_T = CW'(T - 1);
   localparam logic [P-1:0]  V_MAX  = '1;

`ifdef LIF_LEAK_EN
   localparam bit LEAK_ON = 1'b1;
`else
   localparam bit LEAK_ON = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_OUTPUT = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [P-1:0]   thr_q, thr_d;
   logic           mode_q, mode_d;
   logic [P-1:0]   v_q [N];
   logic [P-1:0]   v_d [N];
   logic [P-1:0]   v_upd [N];
   logic [N-1:0]   spk;
   logic [N*T-1:0] spike_q, spike_d;

   // Per-channel datapath: leak, saturating add, threshold compare, reset.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ch
         logic [P-1:0] leak_amt;
         logic [P-1:0] v_leak;
         logic [P:0]   sum;
         logic [P-1:0] v_new;

         assign leak_amt = LEAK_ON ? (v_q[gi] >> LEAK_SHIFT) : '0;
         // The floor shift never exceeds V, so this subtraction cannot wrap.
         assign v_leak   = v_q[gi] - leak_amt;
         // The extra bit catches overflow past 2^P-1 (Q <= P, so one bit suffices).
         assign sum      = {1'b0, v_leak} + {{(P + 1 - Q){1'b0}}, in_data[gi*Q +: Q]};
         assign v_new    = sum[P] ? V_MAX : sum[P-1:0];
         assign spk[gi]  = (v_new > thr_q);
         // A spike implies v_new > thr_q, so the subtraction stays positive.
         assign v_upd[gi] = spk[gi] ? (mode_q ? (v_new - thr_q) : '0) : v_new;
      end
   endgenerate

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      mode_d  = mode_q;
      spike_d = spike_q;
      for (int n = 0; n < N; n++) begin
         v_d[n] = v_q[n];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               thr_d   = threshold;
               mode_d  = reset_mode;
               cnt_d   = '0;
               spike_d = '0;
               for (int n = 0; n < N; n++) begin
                  v_d[n] = '0;
               end
            end
         end
         S_ACCUM: begin
            // in_ready is high for the whole state, so in_valid alone is the handshake.
            if (in_valid) begin
               for (int n = 0; n < N; n++) begin
                  v_d[n] = v_upd[n];
                  spike_d[n*T + int'(cnt_q)] = spk[n];
               end
               if (cnt_q == LAST_T) begin
                  state_d = S_OUTPUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         thr_q   <= '0;
         mode_q  <= 1'b0;
         spike_q <= '0;
         for (int n = 0; n < N; n++) begin
            v_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         thr_q   <= thr_d;
         mode_q  <= mode_d;
         spike_q <= spike_d;
         for (int n = 0; n < N; n++) begin
            v_q[n] <= v_d[n];
         end
      end
   end

   assign in_ready  = (state_q == S_ACCUM);
   assign out_valid = (state_q == S_OUTPUT);
   assign busy      = (state_q != S_IDLE);
   assign spike_out = spike_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;

   localparam int N  = 2;
   localparam int T  = 4;
   localparam int Q  = 8;
   localparam int PA = 10;
   localparam int PB = 9;

`ifdef LIF_LEAK_EN
   localparam logic [7:0] EXP_SUB  = 8'h0A;
   localparam logic [7:0] EXP_SAT  = 8'h00;
   localparam logic [7:0] EXP_LEAK = 8'h04;
`else
   localparam logic [7:0] EXP_SUB  = 8'h06;
   localparam logic [7:0] EXP_SAT  = 8'h04;
   localparam logic [7:0] EXP_LEAK = 8'h0A;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start_a, start_b;
   logic [PA-1:0] thr;
   logic          reset_mode;
   logic          in_valid;
   logic [N*Q-1:0] in_data;
   logic          out_ready;
   logic          in_ready_a, out_valid_a, busy_a;
   logic          in_ready_b, out_valid_b, busy_b;
   logic [N*T-1:0] spike_a, spike_b;
   logic          sel_b;

   lif_neuron_array #(.N(N), .T(T), .Q(Q), .P(PA), .LEAK_SHIFT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .threshold(thr),
      .reset_mode(reset_mode), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .spike_out(spike_a), .busy(busy_a)
   );

   lif_neuron_array #(.N(N), .T(T), .Q(Q), .P(PB), .LEAK_SHIFT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .threshold(thr[PB-1:0]),
      .reset_mode(reset_mode), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .spike_out(spike_b), .busy(busy_b)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Monitors: pop the expected map whenever a DUT completes an output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid_a && out_ready) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output_a actual=%0h required=none", spike_a);
         end else begin
            logic [7:0] e;
            e = exp_a.pop_front();
            $display("txn A spike_map=%02h expected=%02h", spike_a, e);
            check("spike_map_a", 32'(spike_a), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_b && out_ready) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output_b actual=%0h required=none", spike_b);
         end else begin
            logic [7:0] e;
            e = exp_b.pop_front();
            $display("txn B spike_map=%02h expected=%02h", spike_b, e);
            check("spike_map_b", 32'(spike_b), 32'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit b, input logic [PA-1:0] t, input bit m);
      thr = t;
      reset_mode = m;
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] d0, input logic [7:0] d1);
      int k;
      in_data  = {d1, d0};
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!(sel_b ? in_ready_b : in_ready_a) && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (k >= 50) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sel_b ? busy_b : busy_a) && k < 100) begin
         k++;
         tick();
      end
      if (k >= 100) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   // c0/c1 pack the four beats of channel 0/1, beat t in bits [8*t +: 8].
   task automatic run(input bit b, input logic [PA-1:0] t, input bit m,
                      input logic [31:0] c0, input logic [31:0] c1,
                      input int gap, input logic [7:0] expv);
      sel_b = b;
      if (b) exp_b.push_back(expv);
      else   exp_a.push_back(expv);
      pulse_start(b, t, m);
      for (int i = 0; i < 4; i++) begin
         send_beat(c0[8*i +: 8], c1[8*i +: 8]);
         if (i < 3) repeat (gap) tick();
      end
      wait_idle();
      check("queue_drained", b ? exp_b.size() : exp_a.size(), 0);
   endtask

   localparam logic [31:0] B70  = {8'd70, 8'd70, 8'd70, 8'd70};
   localparam logic [31:0] B60  = {8'd60, 8'd60, 8'd60, 8'd60};
   localparam logic [31:0] B255 = {8'd255, 8'd255, 8'd255, 8'd255};
   localparam logic [31:0] CH1X = {8'd0, 8'd50, 8'd50, 8'd101};

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; thr = '0; reset_mode = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel_b = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_spike_out", 32'(spike_a), 0);
      check("reset_out_valid", 32'(out_valid_a), 0);
      check("reset_in_ready", 32'(in_ready_a), 0);
      check("reset_busy", 32'(busy_a), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      run(0, 10'd100, 1'b0, B70, 32'd0, 0, 8'h0A);      // reset-to-zero
      run(0, 10'd100, 1'b1, B70, 32'd0, 0, EXP_SUB);    // reset-by-subtraction
      run(1, 10'd510, 1'b0, B255, 32'd0, 0, EXP_SAT);   // saturation, P=9
      run(0, 10'd100, 1'b0, B60, 32'd0, 0, EXP_LEAK);   // leak stimulus
      run(0, 10'd100, 1'b0, B70, CH1X, 0, 8'h1A);       // both channels active
      run(0, 10'd1023, 1'b0, B255, B255, 0, 8'h00);     // max threshold never spikes
      run(0, 10'd100, 1'b0, B70, 32'd0, 3, 8'h0A);      // gaps between beats

      // Backpressure in OUTPUT, with a start pulse that must be ignored.
      sel_b = 1'b0;
      out_ready = 1'b0;
      exp_a.push_back(8'h0A);
      pulse_start(0, 10'd100, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(8'd70, 8'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid_a), 1);
         check("hold_spike_out", 32'(spike_a), 32'h0A);
         check("hold_in_ready", 32'(in_ready_a), 0);
         @(posedge clk); #1;
         start_a = (i == 1);
         thr = 10'd5;
      end
      start_a = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      check("queue_drained", exp_a.size(), 0);
      tick(); tick();
      check("start_ignored_in_output", 32'(busy_a), 0);

      // Abort after two beats.
      pulse_start(0, 10'd100, 1'b1);
      send_beat(8'd70, 8'd90);
      send_beat(8'd70, 8'd90);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_spike_out", 32'(spike_a), 0);
      check("abort_out_valid", 32'(out_valid_a), 0);
      check("abort_in_ready", 32'(in_ready_a), 0);
      check("abort_busy", 32'(busy_a), 0);
      tick();
      rst_n = 1'b1;
      tick();
      run(0, 10'd100, 1'b0, B70, 32'd0, 0, 8'h0A);      // clean window after abort

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
